// File: rtl/dram_init_streamer.sv
// dram_init_streamer
//   Programs NUM_WORDS consecutive DRAM-CIM rows, starting at BASE_ADDR,
//   with data from an external row generator. For each row the streamer
//   fetches LANES*DATA_W bits over gen_req/gen_ack. It then pulses IO_EN
//   with ADDR/WBL_DATA and waits for wr_done before it moves to the next
//   row. Row addresses wrap modulo 2**ADDR_W.
//   A run ends in FIN with either DONE or ERR/ERR_CODE held until the next
//   accepted START.
//   ERR_CODE values: 01 timeout, 10 abort, 11 verify mismatch.
//
//   Optional feature macro: DRAM_INIT_VERIFY_EN
//     When defined, each written row is read back (RD_EN / rd_done /
//     RBL_DATA) and compared with WBL_DATA before it counts as complete.
//     When undefined, RD_EN is tied low and rd_done/RBL_DATA are unused.
//
// Ports
//   CLK, RSTn             clock (rising edge), asynchronous active-low reset
//   START, BASE_ADDR      begin a run at BASE_ADDR (accepted in IDLE/FIN only)
//   ABORT                 cancel the active run
//   gen_req/gen_addr      row request to the generator, held until gen_ack
//   gen_ack/gen_data      generator response, data valid with gen_ack
//   IO_EN/ADDR/WBL_DATA   one-cycle write strobe, row address, row data
//   wr_done               controller write-complete pulse
//   RD_EN/rd_done/RBL_DATA readback strobe, completion and data (verify only)
//   BUSY/DONE/ERR         run status; DONE and ERR are sticky
//   ERR_CODE              error cause of the last run
//   WORD_CNT              rows completed in the current/last run
module dram_init_streamer #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned LANES       = 16,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned NUM_WORDS   = 64,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     START,
  input  logic [ADDR_W-1:0]        BASE_ADDR,
  input  logic                     ABORT,
  output logic                     gen_req,
  output logic [ADDR_W-1:0]        gen_addr,
  input  logic                     gen_ack,
  input  logic [LANES*DATA_W-1:0]  gen_data,
  output logic                     IO_EN,
  output logic [ADDR_W-1:0]        ADDR,
  output logic [LANES*DATA_W-1:0]  WBL_DATA,
  input  logic                     wr_done,
  output logic                     RD_EN,
  input  logic                     rd_done,
  input  logic [LANES*DATA_W-1:0]  RBL_DATA,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic [1:0]               ERR_CODE,
  output logic [ADDR_W:0]          WORD_CNT
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);

  localparam logic [1:0] EC_TIMEOUT  = 2'b01;
  localparam logic [1:0] EC_ABORT    = 2'b10;
  localparam logic [1:0] EC_MISMATCH = 2'b11;

`ifdef DRAM_INIT_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WRITE, S_WAIT_WR, S_READ, S_WAIT_RD, S_FIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WRITE, S_WAIT_WR, S_FIN
  } state_t;
`endif

  state_t             state;
  logic [ADDR_W-1:0]  cur_addr;
  logic [TMO_W-1:0]   tmo_cnt;

  // The generator address is the registered row pointer itself.
  assign gen_addr = cur_addr;

`ifndef DRAM_INIT_VERIFY_EN
  logic unused_verify_in;
  assign unused_verify_in = ^{rd_done, RBL_DATA};
  assign RD_EN = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      tmo_cnt  <= '0;
      gen_req  <= 1'b0;
      IO_EN    <= 1'b0;
      ADDR     <= '0;
      WBL_DATA <= '0;
`ifdef DRAM_INIT_VERIFY_EN
      RD_EN    <= 1'b0;
`endif
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      ERR_CODE <= 2'b00;
      WORD_CNT <= '0;
    end else begin
      IO_EN <= 1'b0;
`ifdef DRAM_INIT_VERIFY_EN
      RD_EN <= 1'b0;
`endif
      // ABORT outranks every other event of an active run, including
      // done pulses arriving in the same cycle.
      if (ABORT && state != S_IDLE && state != S_FIN) begin
        state    <= S_FIN;
        gen_req  <= 1'b0;
        BUSY     <= 1'b0;
        ERR      <= 1'b1;
        ERR_CODE <= EC_ABORT;
      end else begin
        case (state)
          S_IDLE, S_FIN: begin
            if (START) begin
              cur_addr <= BASE_ADDR;
              gen_req  <= 1'b1;
              BUSY     <= 1'b1;
              DONE     <= 1'b0;
              ERR      <= 1'b0;
              ERR_CODE <= 2'b00;
              WORD_CNT <= '0;
              state    <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (gen_ack) begin
              gen_req  <= 1'b0;
              WBL_DATA <= gen_data;
              ADDR     <= cur_addr;
              IO_EN    <= 1'b1;
              state    <= S_WRITE;
            end
          end
          S_WRITE: begin
            tmo_cnt <= '0;
            state   <= S_WAIT_WR;
          end
          S_WAIT_WR: begin
            if (wr_done) begin
`ifdef DRAM_INIT_VERIFY_EN
              RD_EN <= 1'b1;
              state <= S_READ;
`else
              WORD_CNT <= WORD_CNT + 1'b1;
              if (WORD_CNT == LAST_CNT) begin
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
                state <= S_FIN;
              end else begin
                cur_addr <= cur_addr + 1'b1;
                gen_req  <= 1'b1;
                state    <= S_FETCH;
              end
`endif
            end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
              BUSY     <= 1'b0;
              ERR      <= 1'b1;
              ERR_CODE <= EC_TIMEOUT;
              state    <= S_FIN;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
`ifdef DRAM_INIT_VERIFY_EN
          S_READ: begin
            tmo_cnt <= '0;
            state   <= S_WAIT_RD;
          end
          S_WAIT_RD: begin
            if (rd_done) begin
              if (RBL_DATA == WBL_DATA) begin
                WORD_CNT <= WORD_CNT + 1'b1;
                if (WORD_CNT == LAST_CNT) begin
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                  state <= S_FIN;
                end else begin
                  cur_addr <= cur_addr + 1'b1;
                  gen_req  <= 1'b1;
                  state    <= S_FETCH;
                end
              end else begin
                // ADDR still holds the failing row.
                BUSY     <= 1'b0;
                ERR      <= 1'b1;
                ERR_CODE <= EC_MISMATCH;
                state    <= S_FIN;
              end
            end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
              BUSY     <= 1'b0;
              ERR      <= 1'b1;
              ERR_CODE <= EC_TIMEOUT;
              state    <= S_FIN;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dram_init_streamer.sv
`timescale 1ns/1ps
module tb_dram_init_streamer;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned LANES       = 4;
  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned NUM_WORDS   = 64;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned ROW_W       = DATA_W * LANES;
  localparam int          DEPTH       = 1 << ADDR_W;
`ifdef DRAM_INIT_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              START = 1'b0;
  logic [ADDR_W-1:0] BASE_ADDR = '0;
  logic              ABORT;
  logic              gen_req;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_ack = 1'b0;
  logic [ROW_W-1:0]  gen_data = '0;
  logic              IO_EN;
  logic [ADDR_W-1:0] ADDR;
  logic [ROW_W-1:0]  WBL_DATA;
  logic              wr_done = 1'b0;
  logic              RD_EN;
  logic              rd_done = 1'b0;
  logic [ROW_W-1:0]  RBL_DATA = '0;
  logic              BUSY, DONE, ERR;
  logic [1:0]        ERR_CODE;
  logic [ADDR_W:0]   WORD_CNT;

  logic tb_abort = 1'b0;
  logic abort_drv = 1'b0;
  assign ABORT = tb_abort | abort_drv;

  dram_init_streamer #(
    .DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W),
    .NUM_WORDS(NUM_WORDS), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .BASE_ADDR(BASE_ADDR), .ABORT(ABORT),
    .gen_req(gen_req), .gen_addr(gen_addr), .gen_ack(gen_ack), .gen_data(gen_data),
    .IO_EN(IO_EN), .ADDR(ADDR), .WBL_DATA(WBL_DATA), .wr_done(wr_done),
    .RD_EN(RD_EN), .rd_done(rd_done), .RBL_DATA(RBL_DATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CODE(ERR_CODE), .WORD_CNT(WORD_CNT)
  );

  initial forever #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment configuration and transaction logs
  int cyc = 0;
  int gen_dly_min = 0, gen_dly_max = 0, cur_gen_dly = 0, gen_wait = 0;
  bit gen_waiting = 1'b0;
  int wr_dly_min = 3, wr_dly_max = 3, rd_dly = 2;
  int wr_cd = -1, rd_cd = -1, wr_row = 0, rd_row = 0;
  int withhold_row = -1, abort_row = -1, corrupt_row = -1;
  bit spurious_en = 1'b0;
  bit ack_since_io = 1'b0;
  int io_no_ack = 0, req_drop = 0, rd_cnt = 0;
  bit req_prev = 1'b0, busy_prev = 1'b0;
  int busy_fall_cyc = -1, abort_cyc = -1;
  logic [ADDR_W-1:0] io_addr_q[$];
  logic [ROW_W-1:0]  io_data_q[$];
  int                io_cyc_q[$];
  int                done_cyc_q[$];
  logic [ADDR_W-1:0] gen_addr_q[$];
  logic [ROW_W-1:0]  gen_val_q[$];

  // Generator and DRAM-controller behaviour, evaluated on falling edges.
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      wr_done   = 1'b0;
      rd_done   = 1'b0;
      abort_drv = 1'b0;
      if (!RSTn) begin
        wr_cd = -1; rd_cd = -1; gen_ack = 1'b0; gen_waiting = 1'b0;
        req_prev = 1'b0; busy_prev = 1'b0;
      end else begin
        if (gen_ack) begin
          gen_ack = 1'b0;
          gen_waiting = 1'b0;
        end else if (gen_req) begin
          if (!gen_waiting) begin
            gen_waiting = 1'b1;
            gen_wait = 0;
            cur_gen_dly = int'($urandom_range(gen_dly_max, gen_dly_min));
          end
          if (gen_wait >= cur_gen_dly) begin
            gen_ack = 1'b1;
            gen_data = {$urandom, $urandom};
            gen_addr_q.push_back(gen_addr);
            gen_val_q.push_back(gen_data);
            ack_since_io = 1'b1;
          end else begin
            gen_wait++;
            if (spurious_en && gen_wait == 3) wr_done = 1'b1;
          end
        end else if (req_prev) begin
          req_drop++;
        end

        if (wr_cd > 0) begin
          wr_cd--;
          if (wr_cd == 0) begin
            wr_done = 1'b1;
            wr_cd = -1;
            if (!VERIFY) done_cyc_q.push_back(cyc);
            if (wr_row == abort_row) begin
              abort_drv = 1'b1;
              abort_cyc = cyc;
            end
          end
        end
        if (IO_EN) begin
          io_addr_q.push_back(ADDR);
          io_data_q.push_back(WBL_DATA);
          io_cyc_q.push_back(cyc);
          if (!ack_since_io) io_no_ack++;
          ack_since_io = 1'b0;
          wr_row = io_addr_q.size() - 1;
          if (wr_row != withhold_row) wr_cd = int'($urandom_range(wr_dly_max, wr_dly_min));
        end
`ifdef DRAM_INIT_VERIFY_EN
        if (rd_cd > 0) begin
          rd_cd--;
          if (rd_cd == 0) begin
            rd_done = 1'b1;
            rd_cd = -1;
            done_cyc_q.push_back(cyc);
            RBL_DATA = WBL_DATA;
            if (rd_row == corrupt_row)
              RBL_DATA[3*DATA_W +: DATA_W] = ~RBL_DATA[3*DATA_W +: DATA_W];
          end
        end
        if (RD_EN) begin
          rd_cnt++;
          rd_row = io_addr_q.size() - 1;
          rd_cd = rd_dly;
        end
`else
        if (RD_EN) rd_cnt++;
        rd_done  = 1'($urandom);
        RBL_DATA = {$urandom, $urandom};
`endif
        if (busy_prev && !BUSY) busy_fall_cyc = cyc;
        busy_prev = BUSY;
        req_prev  = gen_req;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic clear_logs();
    io_addr_q.delete(); io_data_q.delete(); io_cyc_q.delete(); done_cyc_q.delete();
    gen_addr_q.delete(); gen_val_q.delete();
    io_no_ack = 0; req_drop = 0; rd_cnt = 0; busy_fall_cyc = -1; abort_cyc = -1;
  endtask

  task automatic start_run(input logic [ADDR_W-1:0] base, output int start_cyc);
    BASE_ADDR = base;
    START = 1'b1;
    start_cyc = cyc;
    step(1);
    START = 1'b0;
    BASE_ADDR = ADDR_W'($urandom);
  endtask

  task automatic wait_idle(input int budget, output bit expired);
    int k;
    k = 0;
    expired = 1'b0;
    while (BUSY && k < budget) begin
      step(1);
      k++;
    end
    if (BUSY) expired = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    step(3);
    n_cmp++; if ({gen_req, IO_EN, RD_EN, BUSY, DONE, ERR} !== 6'b0) begin n_bad++;
      $display("FAIL reset_strobes: got %b expected 000000", {gen_req, IO_EN, RD_EN, BUSY, DONE, ERR}); end
    n_cmp++; if (ADDR !== '0 || gen_addr !== '0) begin n_bad++;
      $display("FAIL reset_addr: got ADDR=%0d gen_addr=%0d expected 0", ADDR, gen_addr); end
    n_cmp++; if (WBL_DATA !== '0) begin n_bad++;
      $display("FAIL reset_wbl: got %h expected 0", WBL_DATA); end
    n_cmp++; if (ERR_CODE !== 2'b00 || WORD_CNT !== '0) begin n_bad++;
      $display("FAIL reset_status: got code=%b cnt=%0d expected 00/0", ERR_CODE, WORD_CNT); end
    RSTn = 1'b1;
    step(3);
    n_cmp++; if (BUSY !== 1'b0 || gen_req !== 1'b0) begin n_bad++;
      $display("FAIL idle_no_start: got busy=%b req=%b expected 0/0", BUSY, gen_req); end
  endtask

  task automatic test_nominal();
    int sc, bad_a, bad_d, bad_l;
    bit exp;
    clear_logs();
    gen_dly_min = 0; gen_dly_max = 0; wr_dly_min = 3; wr_dly_max = 3;
    start_run('0, sc);
    n_cmp++; if (BUSY !== 1'b1) begin n_bad++;
      $display("FAIL nominal_busy: got %b expected 1", BUSY); end
    wait_idle(2000, exp);
    n_cmp++; if (exp) begin n_bad++; $display("FAIL nominal_budget: BUSY still %b expected 0", BUSY); end
    n_cmp++; if (io_addr_q.size() != NUM_WORDS) begin n_bad++;
      $display("FAIL nominal_count: got %0d IO_EN expected %0d", io_addr_q.size(), NUM_WORDS); end
    bad_a = 0; bad_d = 0; bad_l = 0;
    for (int i = 0; i < io_addr_q.size() && i < gen_val_q.size(); i++) begin
      if (io_addr_q[i] !== ADDR_W'(i % DEPTH) || gen_addr_q[i] !== ADDR_W'(i % DEPTH)) bad_a++;
      if (io_data_q[i] !== gen_val_q[i]) bad_d++;
    end
    for (int i = 0; i + 1 < io_cyc_q.size() && i < done_cyc_q.size(); i++)
      if (io_cyc_q[i+1] - done_cyc_q[i] != 2) bad_l++;
    n_cmp++; if (bad_a != 0) begin n_bad++; $display("FAIL nominal_addr: got %0d wrong rows expected 0", bad_a); end
    n_cmp++; if (bad_d != 0) begin n_bad++; $display("FAIL nominal_data: got %0d wrong rows expected 0", bad_d); end
    n_cmp++; if (io_cyc_q.size() == 0 || io_cyc_q[0] - sc != 2) begin n_bad++;
      $display("FAIL start_latency: got %0d expected 2", io_cyc_q.size() == 0 ? -1 : io_cyc_q[0] - sc); end
    n_cmp++; if (bad_l != 0) begin n_bad++; $display("FAIL done_latency: got %0d late rows expected 0", bad_l); end
    n_cmp++; if ({DONE, ERR, ERR_CODE} !== 4'b1000 || WORD_CNT !== 7'(NUM_WORDS)) begin n_bad++;
      $display("FAIL nominal_status: got done=%b err=%b code=%b cnt=%0d expected 1/0/00/%0d",
               DONE, ERR, ERR_CODE, WORD_CNT, NUM_WORDS); end
    n_cmp++; if (rd_cnt != (VERIFY ? NUM_WORDS : 0)) begin n_bad++;
      $display("FAIL nominal_rd_en: got %0d RD_EN expected %0d", rd_cnt, VERIFY ? NUM_WORDS : 0); end
    tb_abort = 1'b1;
    step(2);
    tb_abort = 1'b0;
    step(1);
    n_cmp++; if ({DONE, ERR, BUSY} !== 3'b100) begin n_bad++;
      $display("FAIL abort_in_fin: got done/err/busy=%b expected 100", {DONE, ERR, BUSY}); end
  endtask

  task automatic test_wrap();
    int sc, bad_a, bad_d;
    bit exp;
    logic [ADDR_W-1:0] base;
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      base = ADDR_W'(56 + $urandom_range(7, 0));
      gen_dly_min = 0; gen_dly_max = 3; wr_dly_min = 1; wr_dly_max = 4;
      tb_abort = 1'b1;
      start_run(base, sc);
      tb_abort = 1'b0;
      step(20);
      START = 1'b1; BASE_ADDR = base ^ ADDR_W'(21);
      step(1);
      START = 1'b0;
      wait_idle(3000, exp);
      n_cmp++; if (exp || io_addr_q.size() != NUM_WORDS) begin n_bad++;
        $display("FAIL wrap_count: got %0d IO_EN (expired=%b) expected %0d", io_addr_q.size(), exp, NUM_WORDS); end
      bad_a = 0; bad_d = 0;
      for (int i = 0; i < io_addr_q.size() && i < gen_val_q.size(); i++) begin
        if (io_addr_q[i] !== ADDR_W'((int'(base) + i) % DEPTH)) bad_a++;
        if (io_data_q[i] !== gen_val_q[i]) bad_d++;
      end
      n_cmp++; if (bad_a != 0 || bad_d != 0) begin n_bad++;
        $display("FAIL wrap_seq base=%0d: got %0d bad addr %0d bad data expected 0/0", base, bad_a, bad_d); end
      n_cmp++; if ({DONE, ERR} !== 2'b10 || WORD_CNT !== 7'(NUM_WORDS)) begin n_bad++;
        $display("FAIL wrap_status: got done=%b err=%b cnt=%0d expected 1/0/%0d", DONE, ERR, WORD_CNT, NUM_WORDS); end
    end
  endtask

  task automatic test_timeout();
    int sc, n;
    bit exp;
    clear_logs();
    gen_dly_min = 0; gen_dly_max = 2; wr_dly_min = 1; wr_dly_max = 4; withhold_row = 5;
    start_run(ADDR_W'($urandom), sc);
    wait_idle(600, exp);
    n_cmp++; if (exp) begin n_bad++; $display("FAIL timeout_budget: BUSY still %b expected 0", BUSY); end
    n_cmp++; if ({DONE, ERR, ERR_CODE} !== 4'b0101 || WORD_CNT !== 7'd5) begin n_bad++;
      $display("FAIL timeout_status: got done=%b err=%b code=%b cnt=%0d expected 0/1/01/5",
               DONE, ERR, ERR_CODE, WORD_CNT); end
    n = (io_cyc_q.size() > 5) ? busy_fall_cyc - io_cyc_q[5] : -1;
    n_cmp++; if (n < 15 || n > 20) begin n_bad++;
      $display("FAIL timeout_len: got %0d cycles expected 15..20", n); end
    step(30);
    n_cmp++; if (io_addr_q.size() != 6) begin n_bad++;
      $display("FAIL timeout_strobes: got %0d IO_EN expected 6", io_addr_q.size()); end
    withhold_row = -1;
  endtask

  task automatic test_abort();
    int sc;
    bit exp;
    clear_logs();
    gen_dly_min = 0; gen_dly_max = 0; wr_dly_min = 3; wr_dly_max = 3; abort_row = 10;
    start_run(ADDR_W'($urandom), sc);
    wait_idle(1000, exp);
    n_cmp++; if (exp || {DONE, ERR, ERR_CODE} !== 4'b0110 || WORD_CNT !== 7'd10) begin n_bad++;
      $display("FAIL abort_status: got done=%b err=%b code=%b cnt=%0d expected 0/1/10/10",
               DONE, ERR, ERR_CODE, WORD_CNT); end
    n_cmp++; if (busy_fall_cyc - abort_cyc != 1) begin n_bad++;
      $display("FAIL abort_busy: got %0d cycles to BUSY=0 expected 1", busy_fall_cyc - abort_cyc); end
    n_cmp++; if (io_addr_q.size() != 11) begin n_bad++;
      $display("FAIL abort_strobes: got %0d IO_EN expected 11", io_addr_q.size()); end
    abort_row = -1;
    clear_logs();
    gen_dly_min = 7; gen_dly_max = 7;
    start_run(ADDR_W'($urandom), sc);
    step(3);
    tb_abort = 1'b1;
    step(1);
    tb_abort = 1'b0;
    step(12);
    n_cmp++; if ({BUSY, gen_req, ERR_CODE} !== 4'b0010 || io_addr_q.size() != 0 || WORD_CNT !== '0) begin n_bad++;
      $display("FAIL abort_fetch: got busy=%b req=%b code=%b io=%0d cnt=%0d expected 0/0/10/0/0",
               BUSY, gen_req, ERR_CODE, io_addr_q.size(), WORD_CNT); end
  endtask

  task automatic test_stall();
    int sc, bad_a;
    bit exp;
    logic [ADDR_W-1:0] base;
    clear_logs();
    base = ADDR_W'($urandom);
    gen_dly_min = 7; gen_dly_max = 7; wr_dly_min = 3; wr_dly_max = 3; spurious_en = 1'b1;
    start_run(base, sc);
    wait_idle(4000, exp);
    spurious_en = 1'b0;
    n_cmp++; if (req_drop != 0 || io_no_ack != 0) begin n_bad++;
      $display("FAIL stall_handshake: got req_drop=%0d io_without_ack=%0d expected 0/0", req_drop, io_no_ack); end
    bad_a = 0;
    for (int i = 0; i < io_addr_q.size(); i++)
      if (io_addr_q[i] !== ADDR_W'((int'(base) + i) % DEPTH)) bad_a++;
    n_cmp++; if (exp || io_addr_q.size() != NUM_WORDS || bad_a != 0) begin n_bad++;
      $display("FAIL stall_seq: got %0d IO_EN %0d bad addr expected %0d/0", io_addr_q.size(), bad_a, NUM_WORDS); end
    n_cmp++; if ({DONE, ERR} !== 2'b10 || WORD_CNT !== 7'(NUM_WORDS)) begin n_bad++;
      $display("FAIL stall_status: got done=%b err=%b cnt=%0d expected 1/0/%0d", DONE, ERR, WORD_CNT, NUM_WORDS); end
  endtask

  task automatic test_reset_midrun();
    int sc, n;
    clear_logs();
    gen_dly_min = 0; gen_dly_max = 1; wr_dly_min = 2; wr_dly_max = 3;
    start_run(ADDR_W'($urandom), sc);
    step(15);
    RSTn = 1'b0;
    #1;
    n_cmp++; if ({BUSY, IO_EN, gen_req, DONE, ERR} !== 5'b0 || WORD_CNT !== '0) begin n_bad++;
      $display("FAIL reset_midrun: got busy/io/req/done/err=%b cnt=%0d expected 00000/0",
               {BUSY, IO_EN, gen_req, DONE, ERR}, WORD_CNT); end
    step(3);
    RSTn = 1'b1;
    n = io_addr_q.size();
    step(20);
    n_cmp++; if (io_addr_q.size() != n || BUSY !== 1'b0) begin n_bad++;
      $display("FAIL reset_quiet: got %0d new IO_EN busy=%b expected 0/0", io_addr_q.size() - n, BUSY); end
  endtask

`ifdef DRAM_INIT_VERIFY_EN
  task automatic test_verify();
    int sc;
    bit exp;
    clear_logs();
    gen_dly_min = 0; gen_dly_max = 1; wr_dly_min = 2; wr_dly_max = 3; corrupt_row = 20;
    start_run('0, sc);
    wait_idle(2000, exp);
    n_cmp++; if (exp || {DONE, ERR, ERR_CODE} !== 4'b0111 || ADDR !== ADDR_W'(20) || WORD_CNT !== 7'd20) begin n_bad++;
      $display("FAIL verify_mismatch: got done=%b err=%b code=%b addr=%0d cnt=%0d expected 0/1/11/20/20",
               DONE, ERR, ERR_CODE, ADDR, WORD_CNT); end
    n_cmp++; if (io_addr_q.size() != 21 || rd_cnt != 21) begin n_bad++;
      $display("FAIL verify_strobes: got io=%0d rd=%0d expected 21/21", io_addr_q.size(), rd_cnt); end
    corrupt_row = -1;
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_wrap();
    test_timeout();
    test_abort();
    test_stall();
    test_reset_midrun();
`ifdef DRAM_INIT_VERIFY_EN
    test_verify();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
